// File: rtl/div_unit_if.sv
// Start/stall/done bundle between the execute-stage controller and the divider.
interface div_unit_if #(
   parameter int XLEN = 32
) ();
   // start: one-cycle request, taken only when the divider is idle and kill is low.
   // stall: high from the accepting cycle until the result is ready.
   // done: one-cycle pulse in which result is valid; result then holds until the next accepted start.
   logic            start;
   logic            kill;
   logic [1:0]      op;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            stall;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (output start, kill, op, a, b, input stall, done, result);
   modport slave  (input start, kill, op, a, b, output stall, done, result);
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Define DIV_EARLY_OUT_EN to finish divide-by-zero and signed overflow in one cycle.
module div_unit #(
   parameter int XLEN = 32
) (
   input  logic       clk,
   input  logic       reset,
   div_unit_if.slave  bus,
   output logic [1:0] dbg_state
);
   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic            rem_op_q;
   logic            q_neg_q, r_neg_q, div0_q, ovf_q;
   logic [XLEN-1:0] a_q;
   logic [XLEN-1:0] dq_q;
   logic [XLEN-1:0] dvs_q;
   logic [XLEN-1:0] rem_q;
   logic [XLEN-1:0] res_new, res_hold;

   logic            stall_c, done_c, load, step, finish;
   logic            signed_op, a_neg, b_neg, in_div0, in_ovf;
   logic [XLEN-1:0] a_mag, b_mag;
   logic [XLEN:0]   rem_sh, diff;
   logic            take;
   logic [XLEN-1:0] rem_nxt, dq_nxt, quo_fix, rem_fix, busy_res;

   assign signed_op = ~bus.op[0];
   assign a_neg     = signed_op & bus.a[XLEN-1];
   assign b_neg     = signed_op & bus.b[XLEN-1];
   // -MIN_NEG wraps to itself, which is exactly its unsigned magnitude.
   assign a_mag     = a_neg ? -bus.a : bus.a;
   assign b_mag     = b_neg ? -bus.b : bus.b;
   assign in_div0   = (bus.b == '0);
   assign in_ovf    = signed_op & (bus.a == MIN_NEG) & (bus.b == '1);

   // One restoring step; the extra top bit of diff is the borrow.
   assign rem_sh  = {rem_q, dq_q[XLEN-1]};
   assign diff    = rem_sh - {1'b0, dvs_q};
   assign take    = ~diff[XLEN];
   assign rem_nxt = take ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
   assign dq_nxt  = {dq_q[XLEN-2:0], take};

   assign quo_fix  = q_neg_q ? -dq_nxt : dq_nxt;
   assign rem_fix  = r_neg_q ? -rem_nxt : rem_nxt;
   assign busy_res = div0_q ? (rem_op_q ? a_q : '1) :
                     ovf_q  ? (rem_op_q ? '0 : MIN_NEG) :
                              (rem_op_q ? rem_fix : quo_fix);

`ifdef DIV_EARLY_OUT_EN
   logic [XLEN-1:0] early_res;
   logic            early;
   assign early     = in_div0 | in_ovf;
   assign early_res = in_div0 ? (bus.op[1] ? bus.a : '1) :
                                (bus.op[1] ? '0 : MIN_NEG);
`endif

   always_comb begin
      state_nxt = state;
      stall_c   = 1'b0;
      done_c    = 1'b0;
      load      = 1'b0;
      step      = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start && !bus.kill) begin
               stall_c = 1'b1;
               load    = 1'b1;
`ifdef DIV_EARLY_OUT_EN
               state_nxt = early ? DONE : BUSY;
`else
               state_nxt = BUSY;
`endif
            end
         end
         BUSY: begin
            stall_c = 1'b1;
            if (bus.kill) begin
               state_nxt = IDLE;
            end else begin
               step = 1'b1;
               if (cnt == CW'(XLEN - 1)) begin
                  finish    = 1'b1;
                  state_nxt = DONE;
               end
            end
         end
         DONE: begin
            done_c    = ~bus.kill;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         rem_op_q <= 1'b0;
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
         div0_q   <= 1'b0;
         ovf_q    <= 1'b0;
         a_q      <= '0;
         dq_q     <= '0;
         dvs_q    <= '0;
         rem_q    <= '0;
         res_new  <= '0;
         res_hold <= '0;
      end else begin
         state <= state_nxt;
         if (load) begin
            rem_op_q <= bus.op[1];
            q_neg_q  <= a_neg ^ b_neg;
            r_neg_q  <= a_neg;
            div0_q   <= in_div0;
            ovf_q    <= in_ovf;
            a_q      <= bus.a;
            dq_q     <= a_mag;
            dvs_q    <= b_mag;
            rem_q    <= '0;
            cnt      <= '0;
`ifdef DIV_EARLY_OUT_EN
            if (early) res_new <= early_res;
`endif
         end
         if (step) begin
            rem_q <= rem_nxt;
            dq_q  <= dq_nxt;
            cnt   <= cnt + CW'(1);
         end
         if (finish) res_new <= busy_res;
         // A killed DONE never publishes, so the visible result stays put.
         if (done_c) res_hold <= res_new;
      end
   end

   assign bus.stall  = stall_c & reset;
   assign bus.done   = done_c;
   assign bus.result = done_c ? res_new : res_hold;
   assign dbg_state  = state;
endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit; a negedge monitor checks results and latency from a queue.
module tb_div_unit;
   localparam int XLEN = 32;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;
`ifdef DIV_EARLY_OUT_EN
   localparam int LAT_SPECIAL = 1;
`else
   localparam int LAT_SPECIAL = XLEN + 1;
`endif
   localparam int LAT_NORMAL = XLEN + 1;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] dbg_state;
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_err = 0;
   int         t_start = 0;
   logic [XLEN-1:0] last_res = '0;
   logic       prev_done = 1'b0;

   logic [XLEN-1:0] exp_q[$];
   int              exp_cyc_q[$];

   div_unit_if #(.XLEN(XLEN)) bus ();

   div_unit #(.XLEN(XLEN)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [XLEN-1:0] av, input logic [XLEN-1:0] bv,
                        input logic [XLEN-1:0] exp, input bit special, input bit push);
      @(posedge clk); #1;
      bus.op = op; bus.a = av; bus.b = bv; bus.start = 1'b1;
      t_start = cyc;
      if (push) begin
         exp_q.push_back(exp);
         exp_cyc_q.push_back(t_start + (special ? LAT_SPECIAL : LAT_NORMAL));
         last_res = exp;
      end
      @(negedge clk);
      check("stall_at_start", {31'b0, bus.stall}, 1);
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.a = $urandom; bus.b = $urandom; bus.op = 2'($urandom_range(0, 3));
   endtask

   task automatic wait_idle();
      int n = 0;
      while (exp_q.size() != 0 && n < 80) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL done_timeout: got %0d results outstanding, want 0", exp_q.size());
         exp_q.delete();
         exp_cyc_q.delete();
      end
   endtask

   task automatic step_to(input int target);
      while (cyc < target) begin
         @(posedge clk); #1;
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      logic [XLEN-1:0] e;
      int c;
      if (reset && bus.done) begin
         check("done_single_pulse", {31'b0, prev_done}, 0);
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_done: got done with result 0x%08h, want no done", bus.result);
         end else begin
            e = exp_q.pop_front();
            c = exp_cyc_q.pop_front();
            check("result", bus.result, e);
            check("latency", cyc, c);
         end
      end
      prev_done = bus.done;
   end

   initial begin
      bus.start = 1'b1; bus.kill = 1'b0; bus.op = OP_DIVU; bus.a = 32'd100; bus.b = 32'd7;

      // reset holds everything quiet even with start asserted
      repeat (3) begin
         @(negedge clk);
         check("reset_stall", {31'b0, bus.stall}, 0);
         check("reset_done", {31'b0, bus.done}, 0);
         check("reset_result", bus.result, 0);
         check("reset_state", {30'b0, dbg_state}, {30'b0, S_IDLE});
      end
      bus.start = 1'b0;
      reset = 1'b1;

      // DIVU 100/7 with stall profile across the whole operation
      issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 1'b1);
      for (int k = 1; k <= XLEN + 1; k++) begin
         @(negedge clk);
         check("stall_profile", {31'b0, bus.stall}, (cyc <= t_start + XLEN) ? 32'd1 : 32'd0);
      end
      wait_idle();

      issue(OP_REMU, 32'd100, 32'd7, 32'd2, 1'b0, 1'b1);                      wait_idle();
      issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 1'b1);          wait_idle();
      issue(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b1);          wait_idle();
      issue(OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, 1'b1);                  wait_idle();
      issue(OP_DIV, 32'h8000_0000, 32'd2, 32'hC000_0000, 1'b0, 1'b1);          wait_idle();
      issue(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);         wait_idle();
      issue(OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1); wait_idle();
      issue(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b1);         wait_idle();

      // divide by zero and signed overflow
      issue(OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b1);                  wait_idle();
      issue(OP_REMU, 32'd5, 32'd0, 32'd5, 1'b1, 1'b1);                         wait_idle();
      issue(OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b1);          wait_idle();
      issue(OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1'b1, 1'b1);          wait_idle();
      issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1);  wait_idle();
      issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b1);          wait_idle();

      // second start while busy is ignored
      issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 1'b1);
      step_to(t_start + 3);
      bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd9; bus.b = 32'd3;
      @(negedge clk);
      check("busy_start_stall", {31'b0, bus.stall}, 1);
      check("busy_start_state", {30'b0, dbg_state}, {30'b0, S_BUSY});
      @(posedge clk); #1;
      bus.start = 1'b0;
      wait_idle();

      // kill mid-operation: no done, result unchanged
      issue(OP_DIVU, 32'd9, 32'd3, 32'd3, 1'b0, 1'b0);
      step_to(t_start + 10);
      bus.kill = 1'b1;
      @(negedge clk);
      check("kill_cycle_stall", {31'b0, bus.stall}, 1);
      @(posedge clk); #1;
      bus.kill = 1'b0;
      @(negedge clk);
      check("after_kill_stall", {31'b0, bus.stall}, 0);
      check("after_kill_done", {31'b0, bus.done}, 0);
      check("after_kill_result", bus.result, last_res);
      check("after_kill_state", {30'b0, dbg_state}, {30'b0, S_IDLE});
      repeat (40) @(negedge clk);
      check("kill_result_held", bus.result, last_res);

      // kill together with start in idle: request refused
      @(posedge clk); #1;
      bus.start = 1'b1; bus.kill = 1'b1; bus.op = OP_DIVU; bus.a = 32'd50; bus.b = 32'd5;
      @(negedge clk);
      check("kill_start_stall", {31'b0, bus.stall}, 0);
      @(posedge clk); #1;
      bus.start = 1'b0; bus.kill = 1'b0;
      @(negedge clk);
      check("kill_start_state", {30'b0, dbg_state}, {30'b0, S_IDLE});
      repeat (40) @(negedge clk);

      // asynchronous reset mid-operation
      issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0);
      step_to(t_start + 10);
      bus.start = 1'b1;
      reset = 1'b0;
      #1;
      check("midreset_stall", {31'b0, bus.stall}, 0);
      check("midreset_done", {31'b0, bus.done}, 0);
      check("midreset_result", bus.result, 0);
      check("midreset_state", {30'b0, dbg_state}, {30'b0, S_IDLE});
      last_res = '0;
      @(negedge clk);
      check("midreset_stall_hold", {31'b0, bus.stall}, 0);
      bus.start = 1'b0;
      reset = 1'b1;
      issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 1'b1);
      wait_idle();
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/div_unit.md
# div_unit

Iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits in the Execute stage next to the ALU. It accepts a one-cycle start pulse from the pipelined control path and holds the pipeline with `stall` until the result is ready. It also returns `done` together with a stable `result`. It is the responder to the controller's divide start/stall handshake.

## Interface
- `XLEN`, default 32: operand and result width; must be a power of two, ≥ 8.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low reset (asserted when 0).
- `start` input 1: one-cycle request pulse; sampled only in IDLE.
- `kill` input 1: synchronous abort (pipeline flush); discards the operation in flight.
- `op` input 2: `funct3[1:0]`: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `a` input XLEN: dividend (rs1), valid in the start cycle only.
- `b` input XLEN: divisor (rs2), valid in the start cycle only.
- `stall` output 1: pipeline hold request.
- `done` output 1: one-cycle pulse; `result` is valid in that cycle.
- `result` output XLEN: quotient or remainder. Held until the next accepted `start`.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - `stall = start & ~kill` (combinational), so the requesting instruction is held in the start cycle.
  - On `start & ~kill`:
    - latch `op`, |a|, |b| (absolute values only for signed ops);
    - latch quotient sign `a[XLEN-1]^b[XLEN-1]` and remainder sign `a[XLEN-1]`;
    - clear the count; go to BUSY.
- BUSY:
  - `stall = 1`.
  - Each cycle, do one restoring step: shift the partial remainder left and bring in the next dividend bit. Subtract the divisor; if the difference is non-negative, keep it and set the quotient bit to 1.
  - After XLEN steps, go to DONE.
- DONE:
  - `stall = 0`, `done = 1`, `result` registered, then go to IDLE.
  - Sign fix-up is applied when `result` is registered: negate the quotient if its sign bit is set; negate the remainder if its sign bit is set.
- Required results:
  - Divide by zero: quotient = all ones; remainder = `a`.
  - Signed overflow (`a = 0x80000000`, `b = 0xFFFFFFFF`): quotient = `0x80000000`; remainder = 0.
- `start` in BUSY or DONE is ignored; there is no queueing.
- `kill` in BUSY or DONE: return to IDLE at the next edge with no `done` pulse; `result` keeps its previous value. `kill` with `start` in IDLE: `kill` wins, the request is not accepted and `stall` stays 0.
- Arithmetic:
  - The partial remainder is XLEN+1 bits wide, so the subtract borrow is explicit.
  - The magnitude of -2^31 (0x80000000) is carried as the unsigned value 0x80000000.
  - The counter is `$clog2(XLEN)+1` bits wide.

## Timing
- Reset, while `reset` = 0: state IDLE, `stall = 0`, `done = 0`, `result = 0`, counter 0. This holds regardless of `start`.
- Reset mid-operation: the operation is abandoned immediately; after release the unit is in IDLE.
- Nominal latency (start accepted in cycle T):
  - `stall` is high in cycles T..T+XLEN;
  - `done` and `result` are valid in cycle T+XLEN+1 with `stall` low;
  - for XLEN = 32: stall is high for 33 cycles and the result arrives at T+33.
- Back-to-back: a new `start` is accepted in the cycle after DONE at the earliest.
- `done` is never high for more than one consecutive cycle.

## Configuration
- `DIV_EARLY_OUT_EN` defined:
  - divide-by-zero and signed-overflow cases skip BUSY and go directly to DONE;
  - `stall` is high only in cycle T, and the result is valid at T+1;
  - all other cases behave as above.
- `DIV_EARLY_OUT_EN` undefined:
  - every operation takes the full XLEN+1-cycle latency;
  - special-case results are identical; the fix-up at DONE forces them.

## Test plan
- DIVU `a=100`, `b=7` -> `result=14` at T+33, stall high T..T+32, `done` is a single pulse. The same operands with REMU -> `result=2`.
- DIV `a=0xFFFFFFF9` (-7), `b=2` -> `0xFFFFFFFD` (-3). REM with the same operands -> `0xFFFFFFFF` (-1). REM `a=7`, `b=0xFFFFFFFE` -> `1`.
- Divide by zero, DIV `a=5`, `b=0` -> `0xFFFFFFFF`; REMU `a=5`, `b=0` -> `5`. Result at T+1 with `DIV_EARLY_OUT_EN` defined, at T+33 without it.
- Overflow, DIV `a=0x80000000`, `b=0xFFFFFFFF` -> `0x80000000`; REM -> `0`.
- Abort and ignored start:
  - second `start` at T+3 (DIVU 9/3) while busy -> ignored; the first result (100/7 = 14) is returned at T+33;
  - `kill` at T+10 -> `stall` low at T+11, no `done`, `result` unchanged.
- `reset` pulled low at T+10 -> `stall=0`, `done=0`, `result=0` immediately. After release, DIVU 100/7 completes with 14 at 33 cycles.
